// File: rtl/if_pkg.sv
// if_pkg: shared types for the RV32I instruction-fetch stage.
// Branch-control encodings, fetch FSM states and the fetch buffer entry.
package if_pkg;

   localparam logic [1:0] BR_PC4  = 2'b00;
   localparam logic [1:0] BR_PCB  = 2'b01;
   localparam logic [1:0] BR_PCJR = 2'b10;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DROP
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: 1-entry instruction buffer between memory and IF/ID.
// Clear beats write, write beats consume.
module if_fetch_buf import if_pkg::*; #(
   parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  fetch_entry_t wr_entry,
   input  logic         consume,
   input  logic         clear,
   output fetch_entry_t entry
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         entry <= '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};
      end else if (wr) begin
         entry <= '{pc: wr_entry.pc, instr: wr_entry.instr, valid: 1'b1};
      end else if (consume) begin
         entry.valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: fetch PC, imem handshake, 1-entry buffer, IF/ID register.
// Define IF_PERF_CNT_EN to add the perf_fetched / perf_bubbles counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  branch_ctrl,
   input  logic [31:0] pc_imm,
   input  logic [31:0] pc_jalr,
   input  logic        pc_write,
   input  logic        ifid_write,
   input  logic        instr_flush,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_gnt,
   input  logic        im_rvalid,
   input  logic [31:0] im_rdata,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles
`endif
);

   import if_pkg::*;

   fetch_state_t state, state_nx;
   fetch_entry_t buf_q, rsp_entry;
   logic [31:0]  fetch_pc, pend_pc, target;
   logic         redirect, flush, rsp_ok, bypass;
   logic         buf_wr, consume, room, issue;

   assign redirect = (branch_ctrl == BR_PCB) || (branch_ctrl == BR_PCJR);
   assign target   = (branch_ctrl == BR_PCJR) ? (pc_jalr & 32'hFFFF_FFFE)
                                              : pc_imm;
   assign flush    = instr_flush | redirect;

   // Only a response to our own live request is accepted.
   assign rsp_ok  = im_rvalid & (state == S_WAIT) & ~redirect;
   assign bypass  = rsp_ok & ifid_write & ~flush & ~buf_q.valid;
   assign buf_wr  = rsp_ok & ~bypass;
   assign consume = buf_q.valid & ifid_write & ~flush;
   assign room    = ~((buf_q.valid & ~consume) | buf_wr);

   assign im_req  = ~rst & pc_write & room & ~redirect &
                    ((state == S_REQ) | ((state == S_WAIT) & im_rvalid));
   assign im_addr = fetch_pc;
   assign issue   = im_req & im_gnt;

   assign rsp_entry = '{pc: pend_pc, instr: im_rdata, valid: 1'b1};

   if_fetch_buf #(
      .BUBBLE_INSTR (NOP_INSTR)
   ) u_fetch_buf (
      .clk      (clk),
      .rst      (rst),
      .wr       (buf_wr),
      .wr_entry (rsp_entry),
      .consume  (consume),
      .clear    (redirect),
      .entry    (buf_q)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         S_REQ: begin
            if (issue) state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (redirect) state_nx = im_rvalid ? S_REQ : S_DROP;
            else if (im_rvalid) state_nx = issue ? S_WAIT : S_REQ;
         end
         S_DROP: begin
            if (im_rvalid) state_nx = S_REQ;
         end
         default: state_nx = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_REQ;
         fetch_pc <= RESET_PC;
         pend_pc  <= '0;
      end else begin
         state <= state_nx;
         if (redirect) fetch_pc <= target;
         else if (issue) fetch_pc <= fetch_pc + 32'd4;
         if (issue) pend_pc <= fetch_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_pc    <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
      end else begin
         priority case (1'b1)
            flush: begin
               ifid_pc    <= '0;
               ifid_instr <= NOP_INSTR;
               ifid_valid <= 1'b0;
            end
            ~ifid_write: begin
            end
            buf_q.valid: begin
               ifid_pc    <= buf_q.pc;
               ifid_instr <= buf_q.instr;
               ifid_valid <= 1'b1;
            end
            bypass: begin
               ifid_pc    <= pend_pc;
               ifid_instr <= im_rdata;
               ifid_valid <= 1'b1;
            end
            default: begin
               ifid_pc    <= '0;
               ifid_instr <= NOP_INSTR;
               ifid_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_bubbles <= '0;
      end else begin
         if (rsp_ok) perf_fetched <= perf_fetched + 32'd1;
         if (!ifid_valid) perf_bubbles <= perf_bubbles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed bench for if_fetch_stage with a small
// imem responder (configurable wait states, one outstanding request).
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  branch_ctrl;
   logic [31:0] pc_imm, pc_jalr;
   logic        pc_write, ifid_write, instr_flush;
   logic        im_req, im_gnt, im_rvalid;
   logic [31:0] im_addr, im_rdata;
   logic [31:0] ifid_pc, ifid_instr;
   logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_bubbles;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;

   logic        gnt_en;
   int          wait_states;
   logic        mem_pend;
   logic [31:0] mem_addr;
   int          mem_cnt;
   logic        seen_req;
   logic [31:0] seen_addr;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .branch_ctrl (branch_ctrl),
      .pc_imm      (pc_imm),
      .pc_jalr     (pc_jalr),
      .pc_write    (pc_write),
      .ifid_write  (ifid_write),
      .instr_flush (instr_flush),
      .im_req      (im_req),
      .im_addr     (im_addr),
      .im_gnt      (im_gnt),
      .im_rvalid   (im_rvalid),
      .im_rdata    (im_rdata),
      .ifid_pc     (ifid_pc),
      .ifid_instr  (ifid_instr),
      .ifid_valid  (ifid_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_bubbles (perf_bubbles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive memory response, observe request, advance.
   task automatic tick();
      logic rv_now;
      rv_now    = mem_pend && (mem_cnt == 0);
      im_rvalid = rv_now;
      im_rdata  = rv_now ? (32'h1000_0000 | mem_addr) : 32'hDEAD_BEEF;
      im_gnt    = gnt_en;
      #1;
      seen_req  = im_req;
      seen_addr = im_addr;
      if (rv_now) mem_pend = 1'b0;
      chk("one_outstanding", {31'd0, im_req & im_gnt & mem_pend}, 32'd0);
      if (im_req && im_gnt) begin
         mem_pend = 1'b1;
         mem_addr = im_addr;
         mem_cnt  = wait_states;
      end else if (mem_pend && mem_cnt != 0) begin
         mem_cnt--;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic e;
      rst         = 1'b1;
      branch_ctrl = 2'b00;
      pc_imm      = '0;
      pc_jalr     = '0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      instr_flush = 1'b0;
      im_gnt      = 1'b0;
      im_rvalid   = 1'b0;
      im_rdata    = '0;
      gnt_en      = 1'b1;
      wait_states = 0;
      mem_pend    = 1'b0;
      mem_addr    = '0;
      mem_cnt     = 0;

      tick();
      tick();
      chk("rst_req", {31'd0, seen_req}, 32'd0);
      chk("rst_pc", ifid_pc, 32'd0);
      chk("rst_instr", ifid_instr, 32'h0000_0013);
      chk("rst_valid", {31'd0, ifid_valid}, 32'd0);

      // zero-wait streaming
      rst = 1'b0;
      tick();
      chk("c1_req", {31'd0, seen_req}, 32'd1);
      chk("c1_addr", seen_addr, 32'h0);
      chk("c1_valid", {31'd0, ifid_valid}, 32'd0);
      tick();
      chk("zw_pc0", ifid_pc, 32'h0);
      chk("zw_v0", {31'd0, ifid_valid}, 32'd1);
      chk("zw_i0", ifid_instr, 32'h1000_0000);
      tick();
      chk("zw_pc4", ifid_pc, 32'h4);
      chk("zw_addr8", seen_addr, 32'h8);

      // load-use stall with PC 8 in flight
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      tick();
      chk("st_hold_pc", ifid_pc, 32'h4);
      chk("st_hold_i", ifid_instr, 32'h1000_0004);
      chk("st_noreq1", {31'd0, seen_req}, 32'd0);
      tick();
      chk("st_hold_pc2", ifid_pc, 32'h4);
      chk("st_hold_v2", {31'd0, ifid_valid}, 32'd1);
      chk("st_noreq2", {31'd0, seen_req}, 32'd0);
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      tick();
      chk("st_buf_pc", ifid_pc, 32'h8);
      chk("st_buf_i", ifid_instr, 32'h1000_0008);
      chk("st_addr12", seen_addr, 32'hC);
      wait_states = 1;
      tick();
      chk("st_pc12", ifid_pc, 32'hC);
      chk("st_addr16", seen_addr, 32'h10);

      // PCB redirect while waiting; stale word dropped
      branch_ctrl = 2'b01;
      pc_imm      = 32'h100;
      tick();
      chk("pcb_v", {31'd0, ifid_valid}, 32'd0);
      chk("pcb_noreq", {31'd0, seen_req}, 32'd0);
      branch_ctrl = 2'b00;
      tick();
      chk("pcb_drop_v", {31'd0, ifid_valid}, 32'd0);
      chk("pcb_drop_req", {31'd0, seen_req}, 32'd0);
      tick();
      chk("pcb_req", {31'd0, seen_req}, 32'd1);
      chk("pcb_addr", seen_addr, 32'h100);
      chk("pcb_v2", {31'd0, ifid_valid}, 32'd0);
      tick();
      chk("pcb_v3", {31'd0, ifid_valid}, 32'd0);
      tick();
      chk("pcb_pc", ifid_pc, 32'h100);
      chk("pcb_vd", {31'd0, ifid_valid}, 32'd1);
      chk("pcb_i", ifid_instr, 32'h1000_0100);
      chk("pcb_addr2", seen_addr, 32'h104);
      tick();
      chk("gap_v", {31'd0, ifid_valid}, 32'd0);

      // PCJR coincident with rvalid
      branch_ctrl = 2'b10;
      pc_jalr     = 32'h205;
      tick();
      chk("jr_v", {31'd0, ifid_valid}, 32'd0);
      chk("jr_noreq", {31'd0, seen_req}, 32'd0);
      branch_ctrl = 2'b00;
      wait_states = 0;
      tick();
      chk("jr_addr", seen_addr, 32'h204);
      chk("jr_v2", {31'd0, ifid_valid}, 32'd0);
      tick();
      chk("jr_pc", ifid_pc, 32'h204);
      chk("jr_vd", {31'd0, ifid_valid}, 32'd1);

      // reset while waiting, rvalid lands during reset
      rst = 1'b1;
      tick();
      chk("mr_req", {31'd0, seen_req}, 32'd0);
      chk("mr_pc", ifid_pc, 32'd0);
      chk("mr_instr", ifid_instr, 32'h0000_0013);
      chk("mr_valid", {31'd0, ifid_valid}, 32'd0);
      tick();
      chk("mr_req2", {31'd0, seen_req}, 32'd0);
      rst         = 1'b0;
      wait_states = 3;
      tick();
      chk("mr_first_req", {31'd0, seen_req}, 32'd1);
      chk("mr_first_addr", seen_addr, 32'h0);

      // 3 wait states: one instruction every 4 cycles
      for (int k = 0; k < 8; k++) begin
         e = (k == 3) || (k == 7);
         tick();
         chk("ws3_req", {31'd0, seen_req}, {31'd0, e});
         chk("ws3_valid", {31'd0, ifid_valid}, {31'd0, e});
      end
      chk("ws3_pc", ifid_pc, 32'h4);

      // redirect to the top of memory, fetch PC wraps to 0
      branch_ctrl = 2'b01;
      pc_imm      = 32'hFFFF_FFFC;
      wait_states = 0;
      tick();
      branch_ctrl = 2'b00;
      tick();
      tick();
      tick();
      chk("wr_drop_v", {31'd0, ifid_valid}, 32'd0);
      chk("wr_drop_req", {31'd0, seen_req}, 32'd0);
      tick();
      chk("wr_top_addr", seen_addr, 32'hFFFF_FFFC);
      tick();
      chk("wr_addr0", seen_addr, 32'h0);
      chk("wr_pc", ifid_pc, 32'hFFFF_FFFC);
      chk("wr_vd", {31'd0, ifid_valid}, 32'd1);
      tick();
      chk("wr_pc0", ifid_pc, 32'h0);
      chk("wr_i0", ifid_instr, 32'h1000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
